// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: round-robin arbitration of three result sources onto the
// single write port, plus a busy-bit scoreboard for RAW/WAW hazard detection at issue.
module regfile_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter int NREQ   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [4:0]        alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [4:0]        mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              mul_valid,
    input  logic [4:0]        mul_addr,
    input  logic [DATA_W-1:0] mul_data,
    output logic              mul_ready,
    output logic              wb_write_enable,
    output logic [4:0]        wb_write_addr,
    output logic [DATA_W-1:0] wb_write_data,
    input  logic              reserve_valid,
    input  logic [4:0]        reserve_addr,
    output logic              reserve_stall,
    input  logic [4:0]        chk_addr_a,
    input  logic [4:0]        chk_addr_b,
    output logic              hazard_a,
    output logic              hazard_b,
    input  logic              flush,
    output logic [5:0]        busy_count
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   grant;
    logic [1:0]        rr_ptr;
    logic [1:0]        win_idx;
    logic              grant_any;
    logic [4:0]        win_addr;
    logic [DATA_W-1:0] win_data;

    assign req_valid = {mul_valid, mem_valid, alu_valid};

    // Search starts at rr_ptr and wraps modulo NREQ; the first valid requester wins.
    always_comb begin
        logic [2:0] idx;
        // NOTE: every combinational output gets a default before any branch, so no path leaves it
        // unassigned and no latch is inferred.
        win_idx   = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_ptr} + 3'(i);
            if (idx >= 3'(NREQ)) begin
                idx = idx - 3'(NREQ);
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                win_idx   = idx[1:0];
            end
        end
        grant = grant_any ? (3'b001 << win_idx) : '0;
    end

    assign {mul_ready, mem_ready, alu_ready} = reset ? grant : '0;

    always_comb begin
        win_addr = alu_addr;
        win_data = alu_data;
        case (win_idx)
            2'd1: begin
                win_addr = mem_addr;
                win_data = mem_data;
            end
            2'd2: begin
                win_addr = mul_addr;
                win_data = mul_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr          <= '0;
            wb_write_enable <= 1'b0;
            wb_write_addr   <= '0;
            wb_write_data   <= '0;
        end else if (grant_any) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            rr_ptr          <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
            wb_write_enable <= (win_addr != '0);
            wb_write_addr   <= win_addr;
            wb_write_data   <= win_data;
        end else begin
            wb_write_enable <= 1'b0;
        end
    end

    // Scoreboard; bit 0 is always written as zero so x0 never reads busy.
    logic [31:0] busy;
    logic [31:0] busy_next;
    logic        do_set;
    logic        do_clr;

    assign hazard_a      = busy[chk_addr_a];
    assign hazard_b      = busy[chk_addr_b];
    assign reserve_stall = reserve_valid && (reserve_addr != '0) && busy[reserve_addr];
    assign do_set        = reserve_valid && (reserve_addr != '0) && !busy[reserve_addr];
    assign do_clr        = wb_write_enable && busy[wb_write_addr];

    always_comb begin
        busy_next = busy;
        if (do_clr) begin
            busy_next[wb_write_addr] = 1'b0;
        end
        if (do_set) begin
            busy_next[reserve_addr] = 1'b1;
        end
    end

    // A clear and a set on one edge always target different registers, so the count nets to zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else if (flush) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy <= busy_next & ~32'd1;
            case ({do_set, do_clr})
                2'b10:   busy_count <= busy_count + 6'd1;
                2'b01:   busy_count <= busy_count - 6'd1;
                default: busy_count <= busy_count;
            endcase
        end
    end

endmodule
